// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension result stage: op codes, FSM states,
// operand-flag bit positions and the sign-correction rule.
// No logic of its own; imported by muldiv_out and muldiv_neg64.
package muldiv_pkg;

  // Multiply family op codes (div_i = 0)
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Divide family op codes (div_i = 1)
  localparam logic [1:0] OP_DIV    = 2'b00;
  localparam logic [1:0] OP_DIVU   = 2'b01;
  localparam logic [1:0] OP_REM    = 2'b10;
  localparam logic [1:0] OP_REMU   = 2'b11;

  // Result-stage FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_FIX    = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Bit positions inside ab_status_i = {Bm1,B1,B0,Am1,A1,A0}
  localparam int AB_A0  = 0;
  localparam int AB_A1  = 1;
  localparam int AB_AM1 = 2;
  localparam int AB_B0  = 3;
  localparam int AB_B1  = 4;
  localparam int AB_BM1 = 5;

  // Whether the unsigned core result must be two's-complement negated.
  function automatic logic neg_flag(input logic       div,
                                    input logic [1:0] op,
                                    input logic       a_neg,
                                    input logic       b_neg);
    logic n;
    n = 1'b0;
    if (div) begin
      case (op)
        OP_DIV:           n = a_neg ^ b_neg;
        OP_REM:           n = a_neg;
        OP_DIVU, OP_REMU: n = 1'b0;
        default:          n = 1'b0;
      endcase
    end else begin
      case (op)
        OP_MUL, OP_MULH:  n = a_neg ^ b_neg;
        OP_MULHSU:        n = a_neg;
        OP_MULHU:         n = 1'b0;
        default:          n = 1'b0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/muldiv_neg64.sv
// Conditional 64-bit two's-complement negator for the result stage.
// Default: combinational, 0 cycles. With MULDIV_OUT_PIPE_EN: low word + carry
// registered on load_i, high word finished combinationally the following cycle.
module muldiv_neg64
  import muldiv_pkg::*;
(
`ifdef MULDIV_OUT_PIPE_EN
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
`endif
  input  logic        neg_i,
  input  logic [63:0] val_i,
  output logic [63:0] val_o
);

`ifdef MULDIV_OUT_PIPE_EN
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        neg_q, neg_d;
  logic        cy_q, cy_d;

  // First half: negate low word, remember whether it carries into the high word
  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    neg_d = neg_q;
    cy_d  = cy_q;
    if (load_i) begin
      lo_d  = neg_i ? (~val_i[31:0] + 32'd1) : val_i[31:0];
      hi_d  = val_i[63:32];
      neg_d = neg_i;
      cy_d  = neg_i && (val_i[31:0] == 32'd0);
    end
  end

  // Split-negation state registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lo_q  <= '0;
      hi_q  <= '0;
      neg_q <= 1'b0;
      cy_q  <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      neg_q <= neg_d;
      cy_q  <= cy_d;
    end
  end

  // Second half: -P high word is ~hi plus the carry out of the low word
  always_comb begin
    val_o = {(neg_q ? (~hi_q + {31'd0, cy_q}) : hi_q), lo_q};
  end
`else
  // Single-cycle full-width negation
  always_comb begin
    val_o = neg_i ? (~val_i + 64'd1) : val_i;
  end
`endif

endmodule

// File: rtl/muldiv_out.sv
// Result post-processing for the M-extension unit: sign fix-up, special-case short-circuit, writeback handshake.
// Latency core_valid_i -> res_valid_o 1 cycle (2 with MULDIV_OUT_PIPE_EN); short-circuit result 1 cycle after start_i.
// Result held stable in HOLD until res_ready_i; start_i ignored while busy, core_valid_i ignored outside WAIT.
module muldiv_out
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            div_i,
  input  logic [1:0]      op_i,
  input  logic            a_neg_i,
  input  logic            b_neg_i,
  input  logic [5:0]      ab_status_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic            core_valid_i,
  input  logic [XLEN-1:0] core_hi_i,
  input  logic [XLEN-1:0] core_lo_i,
  output logic            core_kill_o,
  output logic            busy_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o,
  input  logic            res_ready_i
);

  logic [1:0]      state_q, state_d;
  logic            div_q, div_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            vld_q, vld_d;
  logic            kill_q, kill_d;

  logic            short_c;
  logic [XLEN-1:0] short_res;
  logic [63:0]     neg_in;
  logic [63:0]     neg_out;
  logic [XLEN-1:0] fin_res;
  logic            unused_ab;

  // The +/-1 operand flags are consumed by the core, not here
  assign unused_ab = ^{ab_status_i[AB_A1], ab_status_i[AB_AM1],
                       ab_status_i[AB_B1], ab_status_i[AB_BM1]};

  // Special cases resolved at issue without waiting for the core
  always_comb begin
    if (div_i) begin
      short_c   = ab_status_i[AB_B0];
      short_res = op_i[1] ? dividend_i : '1;
    end else begin
      short_c   = ab_status_i[AB_A0] | ab_status_i[AB_B0];
      short_res = '0;
    end
  end

  // Divide only needs one 32-bit word negated: place it in the low half
  always_comb begin
    if (div_q) begin
      neg_in = {32'd0, (op_q[1] ? core_hi_i : core_lo_i)};
    end else begin
      neg_in = {core_hi_i, core_lo_i};
    end
  end

  muldiv_neg64 u_neg64 (
`ifdef MULDIV_OUT_PIPE_EN
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  ((state_q == ST_WAIT) && core_valid_i),
`endif
    .neg_i   (neg_q),
    .val_i   (neg_in),
    .val_o   (neg_out)
  );

  // MUL and the whole divide family return the low word; MULH* the high word
  always_comb begin
    if (div_q || (op_q == OP_MUL)) begin
      fin_res = neg_out[31:0];
    end else begin
      fin_res = neg_out[63:32];
    end
  end

  // FSM next state, context capture and result/valid/kill generation
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    vld_d   = vld_q;
    kill_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          div_d = div_i;
          op_d  = op_i;
          neg_d = neg_flag(div_i, op_i, a_neg_i, b_neg_i);
          if (short_c) begin
            res_d   = short_res;
            vld_d   = 1'b1;
            kill_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (core_valid_i) begin
`ifdef MULDIV_OUT_PIPE_EN
          state_d = ST_FIX;
`else
          res_d   = fin_res;
          vld_d   = 1'b1;
          state_d = ST_HOLD;
`endif
        end
      end
      ST_FIX: begin
        res_d   = fin_res;
        vld_d   = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready_i) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and context registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      div_q   <= 1'b0;
      op_q    <= 2'b00;
      neg_q   <= 1'b0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      kill_q  <= kill_d;
    end
  end

  assign core_kill_o = kill_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign res_valid_o = vld_q;
  assign res_o       = res_q;

endmodule

// File: tb/tb_muldiv_out.sv
// Self-checking bench for muldiv_out: directed corner cases, backpressure, reset, then randomized ops.
// Expected results come from plain 64-bit signed/unsigned arithmetic; the bench also plays the iterative core.
// Build with MULDIV_OUT_PIPE_EN defined to check the 2-cycle configuration.
module tb_muldiv_out;

`ifdef MULDIV_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        div = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        a_neg = 1'b0;
  logic        b_neg = 1'b0;
  logic [5:0]  ab_status = 6'd0;
  logic [31:0] dividend = 32'd0;
  logic        core_valid = 1'b0;
  logic [31:0] core_hi = 32'd0;
  logic [31:0] core_lo = 32'd0;
  logic        core_kill;
  logic        busy;
  logic        res_valid;
  logic [31:0] res;
  logic        res_ready = 1'b0;

  int ntests = 0;
  int nfail  = 0;

  muldiv_out #(.XLEN(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .start_i      (start),
    .div_i        (div),
    .op_i         (op),
    .a_neg_i      (a_neg),
    .b_neg_i      (b_neg),
    .ab_status_i  (ab_status),
    .dividend_i   (dividend),
    .core_valid_i (core_valid),
    .core_hi_i    (core_hi),
    .core_lo_i    (core_lo),
    .core_kill_o  (core_kill),
    .busy_o       (busy),
    .res_valid_o  (res_valid),
    .res_o        (res),
    .res_ready_i  (res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Architectural result, straight from the instruction definitions
  function automatic logic [31:0] ref_res(input logic dv, input logic [1:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (!dv) begin
      case (o)
        2'b00:   p = sa * sb;
        2'b01:   p = sa * sb;
        2'b10:   p = sa * ub;
        default: p = ua * ub;
      endcase
      return (o == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
    case (o)
      2'b00:   p = sa / sb;
      2'b01:   p = ua / ub;
      2'b10:   p = sa % sb;
      default: p = ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Behaviour of the unsigned iterative core on conditioned operands
  task automatic core_model(input logic dv, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] ma, mb;
    logic [63:0] p;
    if (!dv) begin
      ma = mag(a, o != 2'b11);
      mb = mag(b, o == 2'b00 || o == 2'b01);
      p  = {32'd0, ma} * {32'd0, mb};
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      ma = mag(a, !o[0]);
      mb = mag(b, !o[0]);
      hi = (mb == 0) ? ma : (ma % mb);
      lo = (mb == 0) ? 32'hFFFFFFFF : (ma / mb);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_start(input logic dv, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    div       = dv;
    op        = o;
    a_neg     = a[31];
    b_neg     = b[31];
    dividend  = a;
    ab_status = {b == 32'hFFFFFFFF, b == 32'd1, b == 32'd0,
                 a == 32'hFFFFFFFF, a == 32'd1, a == 32'd0};
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue one op, play the core, hold the result under backpressure, accept it
  task automatic do_op(input string tag, input logic dv, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int cdly, input int rdly, input bit poke);
    logic [31:0] exp, hi, lo;
    logic        sc;
    int          n;
    exp = ref_res(dv, o, a, b);
    core_model(dv, o, a, b, hi, lo);
    sc = dv ? (b == 0) : (a == 0 || b == 0);
    drive_start(dv, o, a, b);
    if (sc) begin
      chk({tag, " kill"}, {31'd0, core_kill}, 32'd1);
      chk({tag, " sc_vld"}, {31'd0, res_valid}, 32'd1);
    end else begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      repeat (cdly) @(negedge clk);
      chk({tag, " pre_vld"}, {31'd0, res_valid}, 32'd0);
      core_valid = 1'b1;
      core_hi    = hi;
      core_lo    = lo;
      n = 0;
      do begin
        @(negedge clk);
        core_valid = 1'b0;
        core_hi    = $urandom;
        core_lo    = $urandom;
        n++;
      end while (!res_valid && n < 6);
      chk({tag, " latency"}, n, LAT);
      chk({tag, " no_kill"}, {31'd0, core_kill}, 32'd0);
    end
    chk({tag, " res"}, res, exp);
    for (int i = 0; i < rdly; i++) begin
      if (poke) begin
        start      = 1'b1;
        div        = ~dv;
        op         = ~o;
        ab_status  = 6'b001001;
        core_valid = 1'b1;
      end
      @(negedge clk);
      chk({tag, " hold_vld"}, {31'd0, res_valid}, 32'd1);
      chk({tag, " hold_res"}, res, exp);
      if (sc) chk({tag, " kill_pulse"}, {31'd0, core_kill}, 32'd0);
    end
    start      = 1'b0;
    core_valid = 1'b0;
    res_ready  = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " post_vld"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " post_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, " rst_vld"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " rst_res"}, res, 32'd0);
    chk({tag, " rst_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " rst_kill"}, {31'd0, core_kill}, 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    core_valid = 1'b1;
    core_hi    = 32'h12345678;
    core_lo    = 32'h9ABCDEF0;
    @(negedge clk);
    core_valid = 1'b0;
    @(negedge clk);
    chk({tag, " stale_vld"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " stale_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset vld", {31'd0, res_valid}, 32'd0);
    chk("reset res", res, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset kill", {31'd0, core_kill}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("mul_neg",    1'b0, 2'b00, 32'hFFFFFFFD, 32'd5,        0, 0, 0);
    do_op("mulh_min",   1'b0, 2'b01, 32'h80000000, 32'h80000000, 1, 0, 0);
    do_op("mulhsu",     1'b0, 2'b10, 32'hFFFFFFFF, 32'd2,        0, 1, 0);
    do_op("mul_zero",   1'b0, 2'b11, 32'd0,        32'd9,        0, 1, 0);
    do_op("div_by0",    1'b1, 2'b00, 32'd7,        32'd0,        0, 1, 0);
    do_op("remu_by0",   1'b1, 2'b11, 32'd7,        32'd0,        0, 0, 0);
    do_op("div_ovf",    1'b1, 2'b00, 32'h80000000, 32'hFFFFFFFF, 2, 0, 0);
    do_op("rem_ovf",    1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    do_op("rem_neg",    1'b1, 2'b10, 32'hFFFFFFF9, 32'd2,        1, 0, 0);
    do_op("backpress",  1'b0, 2'b00, 32'h00012345, 32'hFFFF0001, 1, 5, 1);

    // Reset while waiting on the core
    drive_start(1'b1, 2'b00, 32'd100, 32'd7);
    chk("rst_wait busy", {31'd0, busy}, 32'd1);
    reset_pulse("rst_wait");

    // Reset while holding a result
    drive_start(1'b0, 2'b00, 32'd6, 32'd7);
    core_valid = 1'b1;
    core_hi    = 32'd0;
    core_lo    = 32'd42;
    @(negedge clk);
    core_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("rst_hold vld", {31'd0, res_valid}, 32'd1);
    chk("rst_hold res", res, 32'd42);
    reset_pulse("rst_hold");

    for (int i = 0; i < 40; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick(), pick(),
            $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
